// File: rtl/hs_parallel_in_pkg.sv
// Shared definitions for the handshake parallel input port: FSM state encoding,
// default status-bit positions and the bus-decode patterns for {s_, ior_, iow_, a0}.
package hs_parallel_in_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,  // rfd high, waiting for the producer to assert dav_
        StAck  = 2'b01,  // byte captured, waiting for the producer to release dav_
        StHold = 2'b10   // producer released, waiting for the processor to consume the byte
    } state_e;

    localparam int unsigned FiBitDefault = 4;
    localparam int unsigned IeBitDefault = 0;

    // Decode patterns for {s_, ior_, iow_, a0}
    localparam logic [3:0] DecRdRbr = 4'b0010;
    localparam logic [3:0] DecRdSts = 4'b0011;
    localparam logic [3:0] DecWrSts = 4'b0101;

endpackage

// File: rtl/hs_parallel_in_if.sv
// Processor bus strobes, producer handshake and interrupt line for hs_parallel_in.
// The tristate data bus d7_d0 is a plain inout on the top module, not part of this interface.
interface hs_parallel_in_if;

    logic       s_;
    logic       ior_;
    logic       iow_;
    logic       a0;
    logic       dav_;
    logic       rfd;
    logic [7:0] byte_in;
    logic       intr;

    modport slave (
        input  s_, ior_, iow_, a0, dav_, byte_in,
        output rfd, intr
    );

    modport master (
        output s_, ior_, iow_, a0, dav_, byte_in,
        input  rfd, intr
    );

endinterface

// File: rtl/hs_parallel_in_comb.sv
// Pure combinational bus decoder: turns {s_, ior_, iow_, a0} into the three legal
// accesses. Every other pattern, including simultaneous read and write strobes, is no access.
module hs_parallel_in_comb
    import hs_parallel_in_pkg::*;
(
    input  logic s_n_i,
    input  logic ior_n_i,
    input  logic iow_n_i,
    input  logic a0_i,
    output logic rd_rbr_o,
    output logic rd_sts_o,
    output logic wr_sts_o
);

    logic [3:0] sel;

    // Exact-match decode of the strobe/select pattern
    always_comb begin
        sel      = {s_n_i, ior_n_i, iow_n_i, a0_i};
        rd_rbr_o = (sel == DecRdRbr);
        rd_sts_o = (sel == DecRdSts);
        wr_sts_o = (sel == DecWrSts);
    end

endmodule

// File: rtl/hs_parallel_in.sv
// Handshake parallel input port. Captures a producer byte into RBR on dav_ low, raises FI,
// and holds rfd low until the producer has released dav_ and the processor has finished
// reading RBR. Optional feature macro: HS_PARALLEL_IN_IRQ_EN (IE bit and interrupt output).
module hs_parallel_in
    import hs_parallel_in_pkg::*;
#(
    parameter int unsigned FI_BIT = FiBitDefault,
    parameter int unsigned IE_BIT = IeBitDefault
) (
    input  logic             clock,
    input  logic             reset,
    hs_parallel_in_if.slave  bus,
    inout  wire  [7:0]       d7_d0
);

    localparam logic [2:0] FiIdx = 3'(FI_BIT);
    localparam logic [2:0] IeIdx = 3'(IE_BIT);

`ifdef HS_PARALLEL_IN_IRQ_EN
    localparam bit IeEn = 1'b1;
`else
    localparam bit IeEn = 1'b0;
`endif

    // Bits of the status byte that are actually driven; the rest float
    localparam logic [7:0] StsMask = (8'(1) << FiIdx) | (IeEn ? (8'(1) << IeIdx) : 8'h00);

    logic       rd_rbr;
    logic       rd_sts;
    logic       wr_sts;
    logic       rd_done;
    logic       consumed;

    state_e     state_q, state_d;
    logic       rfd_q,   rfd_d;
    logic       fi_q,    fi_d;
    logic [7:0] rbr_q,   rbr_d;
    logic       rd_q,    rd_d;

    logic [7:0] drv_oe;
    logic [7:0] drv_val;

`ifdef HS_PARALLEL_IN_IRQ_EN
    logic       ie_q,  ie_d;
    logic       irq_q, irq_d;
`endif

    hs_parallel_in_comb u_comb (
        .s_n_i    (bus.s_),
        .ior_n_i  (bus.ior_),
        .iow_n_i  (bus.iow_),
        .a0_i     (bus.a0),
        .rd_rbr_o (rd_rbr),
        .rd_sts_o (rd_sts),
        .wr_sts_o (wr_sts)
    );

    // A read of RBR completes on the cycle its strobe goes away
    assign rd_done  = rd_q & ~rd_rbr;
    // Byte no longer pending: either already taken or being taken right now
    assign consumed = ~fi_q | rd_done;

    // Next-state logic for the capture FSM, FI and read tracking
    always_comb begin
        state_d = state_q;
        rfd_d   = rfd_q;
        fi_d    = fi_q;
        rbr_d   = rbr_q;
        rd_d    = rd_rbr;

        if (fi_q && rd_done) begin
            fi_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!bus.dav_) begin
                    rbr_d   = bus.byte_in;
                    fi_d    = 1'b1;
                    rfd_d   = 1'b0;
                    state_d = StAck;
                end
            end
            StAck: begin
                // dav_ low again here is the same strobe still held: never recapture
                if (bus.dav_) begin
                    if (consumed) begin
                        rfd_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (consumed) begin
                    rfd_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                rfd_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            rfd_q   <= 1'b1;
            fi_q    <= 1'b0;
            rbr_q   <= 8'h00;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rfd_q   <= rfd_d;
            fi_q    <= fi_d;
            rbr_q   <= rbr_d;
            rd_q    <= rd_d;
        end
    end

`ifdef HS_PARALLEL_IN_IRQ_EN
    // IE is written from the data bus; the interrupt follows IE & FI on the same edge as FI
    always_comb begin
        ie_d = ie_q;
        if (wr_sts) begin
            ie_d = d7_d0[IeIdx];
        end
        irq_d = ie_d & fi_d;
    end

    // Interrupt-enable and interrupt registers
    always_ff @(posedge clock) begin
        if (reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign bus.intr = irq_q;
`else
    logic unused_wr_sts;
    assign unused_wr_sts = wr_sts;
    assign bus.intr      = 1'b0;
`endif

    assign bus.rfd = rfd_q;

    // Per-bit enables and values for the processor data bus
    always_comb begin
        drv_oe  = 8'h00;
        drv_val = 8'h00;
        if (rd_rbr) begin
            drv_oe  = 8'hFF;
            drv_val = rbr_q;
        end else if (rd_sts) begin
            drv_oe         = StsMask;
            drv_val[FiIdx] = fi_q;
`ifdef HS_PARALLEL_IN_IRQ_EN
            drv_val[IeIdx] = ie_q;
`endif
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_bus_drv
        assign d7_d0[i] = drv_oe[i] ? drv_val[i] : 1'bz;
    end

endmodule

// File: tb/tb_hs_parallel_in.sv
// Self-checking bench for hs_parallel_in: directed handshake scenarios followed by a
// randomized run, all checked against a transaction-level model of the port.
// Undriven bus bits are detected by having the bench drive 0 on every bit the DUT must leave
// floating, so any DUT drive on those bits shows up as 1 or X.
module tb_hs_parallel_in;

    localparam int unsigned FiBit = 4;
    localparam int unsigned IeBit = 0;
`ifdef HS_PARALLEL_IN_IRQ_EN
    localparam logic [7:0] StsMask = (8'h01 << FiBit) | (8'h01 << IeBit);
`else
    localparam logic [7:0] StsMask = (8'h01 << FiBit);
`endif

    logic       clock;
    logic       reset;
    logic [7:0] tb_oe;
    logic [7:0] tb_val;
    wire  [7:0] d7_d0;

    int total;
    int bad;

    hs_parallel_in_if bus_if ();

    hs_parallel_in #(
        .FI_BIT (FiBit),
        .IE_BIT (IeBit)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if),
        .d7_d0 (d7_d0)
    );

    for (genvar i = 0; i < 8; i++) begin : g_tb_drv
        assign d7_d0[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: one byte slot plus producer/consumer progress flags
    logic       m_valid;
    logic       m_rfd;       // port is ready for a new byte
    logic       m_fi;        // byte in the slot not yet read by the processor
    logic [7:0] m_rbr;
    logic       m_released;  // producer has let go of dav_ since the last capture
    logic       m_rd_prev;   // previous cycle was an RBR read
    logic       m_ie;
    logic       m_intr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cur_sel();
        return {bus_if.s_, bus_if.ior_, bus_if.iow_, bus_if.a0};
    endfunction

    function automatic logic [7:0] exp_bus();
        logic [7:0] v;
        v = 8'h00;
        if (cur_sel() == 4'b0010) begin
            v = m_rbr;
        end else if (cur_sel() == 4'b0011) begin
            v[FiBit] = m_fi;
`ifdef HS_PARALLEL_IN_IRQ_EN
            v[IeBit] = m_ie;
`endif
        end
        return v;
    endfunction

    task automatic model_edge();
        logic rd_now;
        logic done_rd;
        rd_now = (cur_sel() == 4'b0010);
        if (reset) begin
            m_valid    = 1'b1;
            m_rfd      = 1'b1;
            m_fi       = 1'b0;
            m_rbr      = 8'h00;
            m_released = 1'b0;
            m_rd_prev  = 1'b0;
            m_ie       = 1'b0;
            m_intr     = 1'b0;
            return;
        end
        done_rd   = m_rd_prev && !rd_now;
        m_rd_prev = rd_now;
        if (done_rd) m_fi = 1'b0;
        if (m_rfd) begin
            if (!bus_if.dav_) begin
                m_rbr      = bus_if.byte_in;
                m_fi       = 1'b1;
                m_rfd      = 1'b0;
                m_released = 1'b0;
            end
        end else begin
            if (bus_if.dav_) m_released = 1'b1;
            // Ready again only once the producer let go and the processor took the byte
            if (m_released && !m_fi) begin
                m_rfd      = 1'b1;
                m_released = 1'b0;
            end
        end
`ifdef HS_PARALLEL_IN_IRQ_EN
        if (cur_sel() == 4'b0101) m_ie = tb_val[IeBit];
        m_intr = m_ie & m_fi;
`endif
    endtask

    task automatic set_bus(input logic s, input logic ior, input logic iow, input logic a0,
                           input logic [7:0] wdata);
        logic [3:0] sel;
        bus_if.s_   = s;
        bus_if.ior_ = ior;
        bus_if.iow_ = iow;
        bus_if.a0   = a0;
        sel         = {s, ior, iow, a0};
        tb_val      = 8'h00;
        if (sel == 4'b0010) begin
            tb_oe = 8'h00;
        end else if (sel == 4'b0011) begin
            tb_oe = ~StsMask;
        end else if (sel == 4'b0101) begin
            tb_oe  = 8'hFF;
            tb_val = wdata;
        end else begin
            tb_oe = 8'hFF;
        end
    endtask

    task automatic bus_idle();
        set_bus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge
    task automatic tick();
        @(negedge clock);
        if (m_valid) begin
            chk("rfd", 8'(bus_if.rfd), 8'(m_rfd));
            chk("int", 8'(bus_if.intr), 8'(m_intr));
            if (cur_sel() != 4'b0101) chk("bus", d7_d0, exp_bus());
        end
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int unsigned op;
        total          = 0;
        bad            = 0;
        m_valid        = 1'b0;
        m_rfd          = 1'b1;
        m_fi           = 1'b0;
        m_rbr          = 8'h00;
        m_released     = 1'b0;
        m_rd_prev      = 1'b0;
        m_ie           = 1'b0;
        m_intr         = 1'b0;
        reset          = 1'b1;
        bus_if.dav_    = 1'b1;
        bus_if.byte_in = 8'h00;
        bus_idle();

        // Reset sequence
        ticks(2);
        reset = 1'b0;
        tick();
        chk("rst_rfd", 8'(bus_if.rfd), 8'h01);
        chk("rst_int", 8'(bus_if.intr), 8'h00);
        #1 chk("rst_bus_z", d7_d0, 8'h00);
        set_bus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        #1 chk("rst_fi", d7_d0, 8'h00);
        tick();
        bus_idle();

        // Single transfer: capture, producer release, then one RBR read
        bus_if.byte_in = 8'hA5;
        bus_if.dav_    = 1'b0;
        tick();
        chk("xfer_rfd_low", 8'(bus_if.rfd), 8'h00);
        bus_if.dav_ = 1'b1;
        set_bus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        #1 chk("xfer_fi_set", d7_d0, 8'h10);
        tick();
        bus_idle();
        ticks(2);
        chk("xfer_hold_rfd", 8'(bus_if.rfd), 8'h00);
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        #1 chk("xfer_rd_a5", d7_d0, 8'hA5);
        tick();
        bus_idle();
        tick();
        chk("xfer_rfd_back", 8'(bus_if.rfd), 8'h01);
        ticks(1);

        // Early read while dav_ is still low
        bus_if.byte_in = 8'h5A;
        bus_if.dav_    = 1'b0;
        tick();
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        ticks(2);
        bus_idle();
        tick();
        set_bus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        #1 chk("early_fi_clr", d7_d0, 8'h00);
        chk("early_rfd_low", 8'(bus_if.rfd), 8'h00);
        bus_if.dav_ = 1'b1;
        tick();
        bus_idle();
        chk("early_rfd_up", 8'(bus_if.rfd), 8'h01);
        ticks(1);

        // Back-pressure: second byte presented while the first is unread
        bus_if.byte_in = 8'hA5;
        bus_if.dav_    = 1'b0;
        tick();
        bus_if.dav_ = 1'b1;
        ticks(2);
        bus_if.byte_in = 8'h3C;
        bus_if.dav_    = 1'b0;
        ticks(3);
        chk("bp_rfd_low", 8'(bus_if.rfd), 8'h00);
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        #1 chk("bp_rbr_kept", d7_d0, 8'hA5);
        tick();
        bus_idle();
        tick();
        chk("bp_rfd_up", 8'(bus_if.rfd), 8'h01);
        tick();
        chk("bp_rfd_low2", 8'(bus_if.rfd), 8'h00);
        bus_if.dav_ = 1'b1;
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        #1 chk("bp_rbr_3c", d7_d0, 8'h3C);
        tick();

        // Status poll with FI set, then illegal strobe combinations
        bus_idle();
        bus_if.byte_in = 8'hC3;
        bus_if.dav_    = 1'b0;
        ticks(2);
        bus_if.dav_ = 1'b1;
        set_bus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        #1 chk("poll_fi", d7_d0, 8'h10);
        tick();
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 chk("illegal_z0", d7_d0, 8'h00);
        tick();
        set_bus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        #1 chk("illegal_z1", d7_d0, 8'h00);
        tick();
        bus_idle();
        tick();
        chk("illegal_nochg", 8'(bus_if.rfd), 8'h00);
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        bus_idle();
        ticks(2);

        // Interrupt enable then a transfer; then disabled
        set_bus(1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
        tick();
        bus_idle();
        bus_if.byte_in = 8'h81;
        bus_if.dav_    = 1'b0;
        tick();
        bus_if.dav_ = 1'b1;
`ifdef HS_PARALLEL_IN_IRQ_EN
        chk("irq_set", 8'(bus_if.intr), 8'h01);
`else
        chk("irq_absent", 8'(bus_if.intr), 8'h00);
`endif
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        bus_idle();
        tick();
        chk("irq_clr", 8'(bus_if.intr), 8'h00);
        set_bus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        tick();
        bus_idle();
        bus_if.byte_in = 8'h42;
        bus_if.dav_    = 1'b0;
        tick();
        bus_if.dav_ = 1'b1;
        tick();
        chk("irq_masked", 8'(bus_if.intr), 8'h00);
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        bus_idle();
        ticks(2);

        // Reset mid-handshake discards the byte
        bus_if.byte_in = 8'h77;
        bus_if.dav_    = 1'b0;
        tick();
        bus_if.dav_ = 1'b1;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_rfd", 8'(bus_if.rfd), 8'h01);
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        #1 chk("midrst_rbr", d7_d0, 8'h00);
        tick();
        bus_idle();
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            op             = $urandom_range(0, 9);
            reset          = ($urandom_range(0, 99) == 0);
            bus_if.dav_    = ($urandom_range(0, 2) != 0);
            bus_if.byte_in = 8'($urandom);
            case (op)
                4, 5:    set_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
                6:       set_bus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
                7:       set_bus(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom));
                8:       set_bus(1'b0, 1'b0, 1'b0, 1'($urandom), 8'h00);
                9:       set_bus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'h00);
                default: bus_idle();
            endcase
            tick();
        end
        reset = 1'b0;
        bus_idle();
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
